// File: rtl/fifo_pkg.sv
// Shared constants and helpers for sync_fifo and its downstream packer.
// Holds the byte width, default FIFO depth, packer states and clog2.
package fifo_pkg;

  localparam int BYTE_W = 8;
  localparam int DEPTH  = 16;

  typedef enum logic {
    PK_FILL,
    PK_FLUSH
  } pk_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/word_hold_reg.sv
// Valid/ready output holding register for packed words.
// Ports: load_i/word_i/keep_i in, ready_i from sink, valid_o/word_o/keep_o out,
// free_o high when a load this cycle is accepted.
module word_hold_reg #(
  parameter int DW = 32,
  parameter int KW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [DW-1:0] word_i,
  input  logic [KW-1:0] keep_i,
  input  logic          ready_i,
  output logic          valid_o,
  output logic [DW-1:0] word_o,
  output logic [KW-1:0] keep_o,
  output logic          free_o
);

  logic          valid_q, valid_d;
  logic [DW-1:0] word_q, word_d;
  logic [KW-1:0] keep_q, keep_d;

  assign free_o  = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign word_o  = word_q;
  assign keep_o  = keep_q;

  // Data holds its last value after acceptance; only valid drops.
  always_comb begin
    valid_d = valid_q && !ready_i;
    word_d  = word_q;
    keep_d  = keep_q;
    if (load_i) begin
      valid_d = 1'b1;
      word_d  = word_i;
      keep_d  = keep_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      word_q  <= '0;
      keep_q  <= '0;
    end else begin
      valid_q <= valid_d;
      word_q  <= word_d;
      keep_q  <= keep_d;
    end
  end

endmodule

// File: rtl/fifo_word_packer.sv
// Packs bytes read from sync_fifo into BYTES_PER_WORD-byte words with keep mask.
// Ports: FIFO read side (empty/data/rd_en), flush_i, valid/ready word output.
module fifo_word_packer #(
  parameter int BYTES_PER_WORD = 4,
  parameter int BYTE_W         = fifo_pkg::BYTE_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             fifo_empty_i,
  input  logic [BYTE_W-1:0]                fifo_data_i,
  output logic                             fifo_rd_en_o,
  input  logic                             flush_i,
  output logic [BYTES_PER_WORD*BYTE_W-1:0] word_o,
  output logic [BYTES_PER_WORD-1:0]        keep_o,
  output logic                             word_valid_o,
  input  logic                             word_ready_i
);

  import fifo_pkg::*;

  localparam int N  = BYTES_PER_WORD;
  localparam int CW = clog2(N) + 1;
  localparam int WW = N * BYTE_W;

  localparam logic [CW-1:0] CNT_FULL = CW'(N);

  logic [CW-1:0] cnt_q, cnt_d, cnt_w;
  logic [WW-1:0] acc_q, acc_d, acc_w;
  logic          rd_pend_q;
  logic          flush_req_q, flush_req_d;
  pk_state_e     state_q, state_d;

  logic          load;
  logic [N-1:0]  ld_keep;
  logic [N-1:0]  part_keep;
  logic          out_free;

  // cnt_w/acc_w: accumulator after this cycle's capture, so a word
  // completed by the capture can go straight to the output register.
  assign cnt_w = cnt_q + {{(CW-1){1'b0}}, rd_pend_q};

  // A read is safe if its byte has a lane next cycle: either there is
  // room now, or the word completing now is certain to move out
  // because the output register is empty (no dependence on ready).
  assign fifo_rd_en_o = !rst && !fifo_empty_i && !flush_req_q &&
                        ((cnt_w < CNT_FULL) ||
                         ((cnt_w == CNT_FULL) && !word_valid_o));

  always_comb begin
    acc_w = acc_q;
    for (int i = 0; i < N; i++) begin
      if (rd_pend_q && (cnt_q == CW'(i)))
        acc_w[i*BYTE_W +: BYTE_W] = fifo_data_i;
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++)
      part_keep[i] = (CW'(i) < cnt_q);
  end

  always_comb begin
    load        = 1'b0;
    ld_keep     = '1;
    acc_d       = acc_w;
    cnt_d       = cnt_w;
    state_d     = state_q;
    flush_req_d = flush_req_q;

    if ((cnt_w == CNT_FULL) && out_free) begin
      load  = 1'b1;
      acc_d = '0;
      cnt_d = '0;
    end else if ((state_q == PK_FLUSH) && !rd_pend_q &&
                 (cnt_q != '0) && out_free) begin
      load    = 1'b1;
      ld_keep = part_keep;
      acc_d   = '0;
      cnt_d   = '0;
    end

    unique case (state_q)
      PK_FILL: begin
        if (flush_i) begin
          state_d     = PK_FLUSH;
          flush_req_d = 1'b1;
        end
      end
      PK_FLUSH: begin
        if (!rd_pend_q && ((cnt_q == '0) || load)) begin
          state_d     = PK_FILL;
          flush_req_d = 1'b0;
        end
      end
      default: begin
        state_d     = PK_FILL;
        flush_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      rd_pend_q   <= 1'b0;
      flush_req_q <= 1'b0;
      state_q     <= PK_FILL;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      rd_pend_q   <= fifo_rd_en_o;
      flush_req_q <= flush_req_d;
      state_q     <= state_d;
    end
  end

  word_hold_reg #(
    .DW(WW),
    .KW(N)
  ) u_hold (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .word_i  (acc_w),
    .keep_i  (ld_keep),
    .ready_i (word_ready_i),
    .valid_o (word_valid_o),
    .word_o  (word_o),
    .keep_o  (keep_o),
    .free_o  (out_free)
  );

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer with a byte FIFO model in front.
// Expected words are hand-computed constants.
module tb_fifo_word_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_empty_i;
  logic [7:0]  fifo_data_i = '0;
  logic        fifo_rd_en_o;
  logic        flush_i = 1'b0;
  logic [31:0] word_o;
  logic [3:0]  keep_o;
  logic        word_valid_o;
  logic        word_ready_i = 1'b0;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int rd_empty_n = 0;
  int wp = 0;
  int rp = 0;
  int unstable;

  logic [7:0]  fmem [256];
  logic [31:0] got_w [$];
  logic [3:0]  got_k [$];
  int          rd_cyc [$];
  int          v_cyc [$];

  fifo_word_packer #(
    .BYTES_PER_WORD(4),
    .BYTE_W(8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty_i (fifo_empty_i),
    .fifo_data_i  (fifo_data_i),
    .fifo_rd_en_o (fifo_rd_en_o),
    .flush_i      (flush_i),
    .word_o       (word_o),
    .keep_o       (keep_o),
    .word_valid_o (word_valid_o),
    .word_ready_i (word_ready_i)
  );

  always #5 clk = ~clk;

  // FIFO model: one-cycle registered read.
  assign fifo_empty_i = (rp == wp);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en_o && (rp != wp)) begin
      fifo_data_i <= fmem[rp[7:0]];
      rp <= rp + 1;
    end
  end

  always @(negedge clk) begin
    if (fifo_rd_en_o && fifo_empty_i) rd_empty_n++;
    if (fifo_rd_en_o) rd_cyc.push_back(cyc);
    if (word_valid_o) v_cyc.push_back(cyc);
    if (word_valid_o && word_ready_i) begin
      got_w.push_back(word_o);
      got_k.push_back(keep_o);
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] b);
    fmem[wp[7:0]] = b;
    wp = wp + 1;
  endtask

  task automatic clr();
    got_w.delete();
    got_k.delete();
    rd_cyc.delete();
    v_cyc.delete();
  endtask

  task automatic pulse_flush();
    flush_i = 1'b1;
    tick(1);
    flush_i = 1'b0;
  endtask

  task automatic wait_words(input string tag, input int n,
                            input int budget);
    int k;
    k = 0;
    while ((got_w.size() < n) && (k < budget)) begin
      tick(1);
      k++;
    end
    check(tag, got_w.size(), n);
  endtask

  task automatic expect_word(input string tag, input int idx,
                             input logic [31:0] w,
                             input logic [3:0] k);
    if (got_w.size() > idx) begin
      check({tag, "_word"}, got_w[idx], w);
      check({tag, "_keep"}, 32'(got_k[idx]), 32'(k));
    end else begin
      check({tag, "_missing"}, got_w.size(), idx + 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    tick(2);
    check("rst_valid", 32'(word_valid_o), 0);
    check("rst_keep", 32'(keep_o), 0);
    check("rst_word", word_o, 0);
    check("rst_rd_en", 32'(fifo_rd_en_o), 0);
    rst = 1'b0;
    tick(1);

    // Reset mid-operation: one word held, two bytes in acc
    word_ready_i = 1'b0;
    for (int b = 1; b <= 6; b++) push(8'(b));
    tick(12);
    check("mid_valid", 32'(word_valid_o), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(word_valid_o), 0);
    check("mid_rst_word", word_o, 0);
    check("mid_rst_keep", 32'(keep_o), 0);
    push(8'h21);
    #1;
    check("mid_rst_rd_en", 32'(fifo_rd_en_o), 0);
    tick(2);
    rst = 1'b0;
    clr();
    word_ready_i = 1'b1;
    push(8'h22);
    push(8'h23);
    push(8'h24);
    wait_words("post_rst_n", 1, 20);
    expect_word("post_rst", 0, 32'h24232221, 4'hF);

    // Streaming, sink always ready
    tick(3);
    clr();
    for (int b = 1; b <= 8; b++) push(8'(8'h11 * b));
    wait_words("stream_n", 2, 30);
    expect_word("stream0", 0, 32'h44332211, 4'hF);
    expect_word("stream1", 1, 32'h88776655, 4'hF);
    check("stream_rd_count", rd_cyc.size(), 8);
    if (rd_cyc.size() >= 8) begin
      check("stream_no_gap", rd_cyc[7] - rd_cyc[0], 7);
      if (v_cyc.size() >= 2) begin
        check("stream_lat0", v_cyc[0], rd_cyc[3] + 2);
        check("stream_lat1", v_cyc[1], rd_cyc[7] + 2);
      end
    end

    // Backpressure: 12 bytes, sink stalled for 10 cycles
    tick(3);
    clr();
    word_ready_i = 1'b0;
    for (int b = 1; b <= 12; b++) push(8'(b));
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (word_valid_o &&
          ((word_o !== 32'h04030201) || (keep_o !== 4'hF)))
        unstable++;
    end
    check("bp_valid", 32'(word_valid_o), 1);
    check("bp_stable", unstable, 0);
    check("bp_none_taken", got_w.size(), 0);
    check("bp_rd_stalled", rd_cyc.size(), 8);
    check("bp_rd_en_low", 32'(fifo_rd_en_o), 0);
    word_ready_i = 1'b1;
    wait_words("bp_n", 3, 40);
    expect_word("bp0", 0, 32'h04030201, 4'hF);
    expect_word("bp1", 1, 32'h08070605, 4'hF);
    expect_word("bp2", 2, 32'h0C0B0A09, 4'hF);
    check("bp_rd_total", rd_cyc.size(), 12);

    // Flush of a 3-byte partial word
    tick(3);
    clr();
    push(8'hA1);
    push(8'hB2);
    push(8'hC3);
    tick(6);
    check("fl_none_yet", got_w.size(), 0);
    pulse_flush();
    wait_words("fl_n", 1, 10);
    expect_word("fl_part", 0, 32'h00C3B2A1, 4'b0111);
    push(8'h10);
    push(8'h20);
    push(8'h30);
    push(8'h40);
    wait_words("fl_next_n", 2, 20);
    expect_word("fl_next", 1, 32'h40302010, 4'hF);

    // Flush with nothing accumulated
    tick(3);
    clr();
    pulse_flush();
    tick(6);
    check("fl0_none", got_w.size(), 0);
    check("fl0_valid", 32'(word_valid_o), 0);

    // Flush while a read is in flight
    clr();
    push(8'h5A);
    push(8'h6B);
    pulse_flush();
    wait_words("flp_n", 1, 10);
    expect_word("flp", 0, 32'h0000005A, 4'b0001);
    push(8'h7C);
    push(8'h8D);
    push(8'h9E);
    wait_words("flp_next_n", 2, 20);
    expect_word("flp_next", 1, 32'h9E8D7C6B, 4'hF);

    // Flush in the cycle the word completes
    tick(3);
    clr();
    push(8'hC1);
    push(8'hC2);
    push(8'hC3);
    push(8'hC4);
    tick(4);
    pulse_flush();
    tick(8);
    check("flf_n", got_w.size(), 1);
    expect_word("flf", 0, 32'hC4C3C2C1, 4'hF);

    // Empty FIFO with random flush/ready activity
    tick(2);
    clr();
    for (int i = 0; i < 40; i++) begin
      flush_i      = 1'($urandom_range(0, 1));
      word_ready_i = 1'($urandom_range(0, 1));
      tick(1);
    end
    flush_i = 1'b0;
    word_ready_i = 1'b1;
    tick(4);
    check("empty_no_rd", rd_cyc.size(), 0);
    check("empty_valid", 32'(word_valid_o), 0);
    check("empty_none", got_w.size(), 0);
    check("rd_when_empty", rd_empty_n, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
